// File: rtl/keypad_pkg.sv
// Shared constants, types and helpers for the 4x4 keypad matrix scanner.
package keypad_pkg;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int NKEYS = ROWS * COLS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE
    } scan_state_e;

    typedef logic [3:0]               key_idx_t;
    typedef logic [$clog2(ROWS)-1:0]  row_idx_t;

    // Active-low one-hot strobe for the given row.
    function automatic logic [ROWS-1:0] row_strobe_n(input row_idx_t row);
        logic [ROWS-1:0] onehot;
        onehot      = '0;
        onehot[row] = 1'b1;
        return ~onehot;
    endfunction

    function automatic key_idx_t lowest_set(input logic [NKEYS-1:0] vec);
        key_idx_t idx;
        idx = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (vec[i]) idx = key_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key debouncer: the stable state flips only after DEBOUNCE_SCANS
// consecutive samples that disagree with it; change_o strobes on the flip.
module key_debounce #(
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_i,
    input  logic raw_i,
    output logic state_o,
    output logic change_o
);

    localparam int            CW       = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            state_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // The counter never holds more than DEBOUNCE_SCANS-1: the sample that
    // would reach DEBOUNCE_SCANS toggles the state and clears it instead.
    always_comb begin
        cnt_d    = cnt_q;
        state_d  = state_q;
        change_o = 1'b0;
        if (sample_i) begin
            if (raw_i == state_q) begin
                cnt_d = '0;
            end else if (cnt_q >= CNT_LAST) begin
                cnt_d    = '0;
                state_d  = ~state_q;
                change_o = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad matrix scanner: row strobing, column sampling, per-key debounce
// and a lowest-index-first event queue.
//   state     | meaning
//   ST_IDLE   | out of reset, all rows released
//   ST_DRIVE  | current row strobed low, first cycle
//   ST_SETTLE | row held low while the column lines settle
//   ST_SAMPLE | columns captured into the current row's debouncers
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [COLS-1:0]  cols_n,
    output logic [ROWS-1:0]  rows_n,
    output logic [NKEYS-1:0] keys,
    output logic             evt_valid,
    output key_idx_t         evt_code,
    output logic             evt_press
);

    localparam int            SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    scan_state_e      state_q, state_d;
    row_idx_t         row_q, row_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [COLS-1:0]  cols_meta_q, cols_sync_q;
    logic [NKEYS-1:0] pending_q, pending_d;
    logic [NKEYS-1:0] change;
    logic [NKEYS-1:0] clr_mask;
    logic             sample_en;

    // Columns idle high, so the synchronizer resets to the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cols_meta_q <= '1;
            cols_sync_q <= '1;
        end else begin
            cols_meta_q <= cols_n;
            cols_sync_q <= cols_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            settle_q  <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            settle_q  <= settle_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        settle_d = settle_q;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_DRIVE;
                row_d   = '0;
            end
            ST_DRIVE: begin
                state_d  = ST_SETTLE;
                settle_d = SETTLE_LOAD;
            end
            ST_SETTLE: begin
                if (settle_q == '0) state_d = ST_SAMPLE;
                else                settle_d = settle_q - SW'(1);
            end
            ST_SAMPLE: begin
                state_d = ST_DRIVE;
                row_d   = row_q + row_idx_t'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rows_n    = '1;
        sample_en = 1'b0;
        if (state_q != ST_IDLE) rows_n = row_strobe_n(row_q);
        if (state_q == ST_SAMPLE) sample_en = 1'b1;
    end

    for (genvar k = 0; k < NKEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
        ) u_key (
            .clk      (clk),
            .rst_n    (rst_n),
            .sample_i (sample_en && (row_q == row_idx_t'(k / COLS))),
            .raw_i    (~cols_sync_q[k % COLS]),
            .state_o  (keys[k]),
            .change_o (change[k])
        );
    end

    // A fresh change on the key being reported re-arms its pending bit.
    always_comb begin
        evt_valid = |pending_q;
        evt_code  = lowest_set(pending_q);
        evt_press = evt_valid & keys[evt_code];
        clr_mask  = '0;
        if (evt_valid) clr_mask[evt_code] = 1'b1;
        pending_d = (pending_q & ~clr_mask) | change;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The module SHALL have parameter SETTLE_CYCLES, default 16: idle cycles between row assertion and column sample.
REQ-002 The module SHALL have parameter DEBOUNCE_SCANS, default 8: consecutive identical full-scan samples required to change a key's debounced state.
REQ-003 The module SHALL have port clk  input  1  system clock (12 MHz on board).
REQ-004 The module SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 The module SHALL have port cols_n  input  4  column lines, active-low, externally pulled high; bit c is column c.
REQ-006 The module SHALL have port rows_n  output  4  row strobes, active-low one-hot; bit r is row r.
REQ-007 The module SHALL have port keys  output  16  debounced pressed mask; bit (4*row + col).
REQ-008 The module SHALL have port evt_valid  output  1  one-cycle pulse, one key-state change reported.
REQ-009 The module SHALL have port evt_code  output  4  key index of the reported change, valid with evt_valid.
REQ-010 The module SHALL have port evt_press  output  1  1 = press, 0 = release, valid with evt_valid.

Function
REQ-011 cols_n SHALL pass through a 2-flop synchronizer before any use.
REQ-012 Scan FSM states SHALL be DRIVE (1 cycle), SETTLE (SETTLE_CYCLES cycles), SAMPLE (1 cycle), in that order; SAMPLE -> DRIVE of next row.
REQ-013 Row index SHALL advance 0,1,2,3 and wrap 3 -> 0; exactly one rows_n bit low in DRIVE, SETTLE, SAMPLE; never two rows low in the same cycle.
REQ-014 Row period SHALL be SETTLE_CYCLES+2 cycles; full scan 4*(SETTLE_CYCLES+2) cycles.
REQ-015 In SAMPLE, raw[4*row+c] SHALL be ~cols_sync[c] for c = 0..3; other rows' raw bits unchanged.
REQ-016 Per key: if raw equals keys[i], debounce counter clears; otherwise counter increments on that key's sample; on reaching DEBOUNCE_SCANS, keys[i] toggles, counter clears, pending[i] sets.
REQ-017 A raw value differing from keys[i] for fewer than DEBOUNCE_SCANS consecutive samples SHALL leave keys[i] unchanged and produce no event.
REQ-018 Each cycle with pending nonzero, the module SHALL assert evt_valid with evt_code = lowest set index, evt_press = keys[evt_code], and clear that pending bit.
REQ-019 Simultaneous changes SHALL be reported one per cycle, ascending index, consecutive cycles; none lost.
REQ-020 If pending[i] sets in the same cycle pending[i] is being cleared, set SHALL win.
REQ-021 Counter arithmetic SHALL be unsigned, width $clog2(DEBOUNCE_SCANS+1), saturating at DEBOUNCE_SCANS.
REQ-022 Ghosting (3+ keys forming a rectangle) SHALL NOT be resolved; raw matrix reading is reported as-is.

Reset
REQ-023 While rst_n low: rows_n = 4'b1111, keys = 0, evt_valid = 0, evt_code = 0, evt_press = 0, all counters, pending and synchronizer flops 0/idle.
REQ-024 Reset asserted mid-scan or mid-event-drain SHALL abort immediately; pending events discarded.
REQ-025 After rst_n deasserts, the first DRIVE SHALL be row 0 on the next rising clk edge.

Structure
REQ-026 Package keypad_pkg SHALL hold ROWS=4, COLS=4, NKEYS=16, the scan state enum, and key_idx_t (4-bit).
REQ-027 One sub-module, key_debounce (single key: counter, stable state, change strobe), SHALL be instantiated NKEYS times; FSM, synchronizer, pending-encoder stay in keypad_scanner.

Verification (SETTLE_CYCLES=4, DEBOUNCE_SCANS=3, scan = 24 cycles)
REQ-028 Reset, no keys -> rows_n cycles 1110,1101,1011,0111 each 6 cycles; keys stays 0; no evt_valid.
REQ-029 Press key 5 (row 1, col 1) held -> keys[5]=1 within 96 cycles of press; one evt_valid with evt_code=5, evt_press=1.
REQ-030 Release key 5 -> keys[5]=0 within 96 cycles; one evt_valid, evt_code=5, evt_press=0.
REQ-031 Key 10 asserted for 30 cycles only (< 3 samples) -> keys unchanged, no event.
REQ-032 Keys 8 and 11 pressed in same cycle -> evt_code=8 then evt_code=11 on consecutive cycles, both evt_press=1; keys = 16'h0900.
REQ-033 rst_n pulsed low while key 3 held and mid-SETTLE -> rows_n=1111 and keys=0 immediately; after release of reset, key 3 re-debounced and evt_code=3 reported once.
